// File: rtl/rs_div_if.sv
// rtl/rs_div_if.sv - dispatch, CDB snoop, divider and result-broadcast bundle for rs_div
interface rs_div_if #(
    parameter int TAG_W = 4
);
    logic             flush;
    logic             disp_valid;
    logic             disp_ready;
    logic [TAG_W-1:0] disp_qj;
    logic [31:0]      disp_vj;
    logic [TAG_W-1:0] disp_qk;
    logic [31:0]      disp_vk;
    logic [TAG_W-1:0] disp_tag;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [31:0]      cdb_data;
    logic             fu_en;
    logic [31:0]      fu_a;
    logic [31:0]      fu_b;
    logic             fu_finish;
    logic [31:0]      fu_res;
    logic             out_req;
    logic [TAG_W-1:0] out_tag;
    logic [31:0]      out_data;
    logic             out_grant;

    modport master (
        output flush, disp_valid, disp_qj, disp_vj, disp_qk, disp_vk,
        input  disp_ready, disp_tag,
        output cdb_valid, cdb_tag, cdb_data,
        input  fu_en, fu_a, fu_b,
        output fu_finish, fu_res,
        input  out_req, out_tag, out_data,
        output out_grant
    );

    modport slave (
        input  flush, disp_valid, disp_qj, disp_vj, disp_qk, disp_vk,
        output disp_ready, disp_tag,
        input  cdb_valid, cdb_tag, cdb_data,
        output fu_en, fu_a, fu_b,
        input  fu_finish, fu_res,
        output out_req, out_tag, out_data,
        input  out_grant
    );
endinterface

// File: rtl/rs_div.sv
// rtl/rs_div.sv - reservation station feeding a single divide unit
module rs_div #(
    parameter int N_ENT    = 2,
    parameter int TAG_W    = 4,
    parameter int BASE_TAG = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    rs_div_if.slave bus
);
    localparam int IW = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_EXEC, ST_DONE} ent_st_t;

    ent_st_t          st_q  [N_ENT];
    ent_st_t          st_d  [N_ENT];
    logic [TAG_W-1:0] qj_q  [N_ENT];
    logic [TAG_W-1:0] qj_d  [N_ENT];
    logic [TAG_W-1:0] qk_q  [N_ENT];
    logic [TAG_W-1:0] qk_d  [N_ENT];
    logic [31:0]      vj_q  [N_ENT];
    logic [31:0]      vj_d  [N_ENT];
    logic [31:0]      vk_q  [N_ENT];
    logic [31:0]      vk_d  [N_ENT];
    logic [31:0]      res_q [N_ENT];
    logic [31:0]      res_d [N_ENT];

    // fu_busy covers the divider itself; orphan marks a divide whose owner was flushed
    logic             fu_busy_q, fu_busy_d;
    logic             orphan_q, orphan_d;
    logic             fu_en_q, fu_en_d;
    logic [31:0]      fu_a_q, fu_a_d;
    logic [31:0]      fu_b_q, fu_b_d;

    logic             free_found, rdy_found, exec_found, done_found;
    logic [IW-1:0]    free_idx, rdy_idx, exec_idx, done_idx;
    logic             cdb_hit;
    logic             byp_j, byp_k;

    // Priority finders: lowest index wins in every category
    always_comb begin
        free_found = 1'b0;
        rdy_found  = 1'b0;
        exec_found = 1'b0;
        done_found = 1'b0;
        free_idx   = '0;
        rdy_idx    = '0;
        exec_idx   = '0;
        done_idx   = '0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (st_q[i] == ST_FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            if (st_q[i] == ST_WAIT && qj_q[i] == '0 && qk_q[i] == '0) begin
                rdy_found = 1'b1;
                rdy_idx   = IW'(i);
            end
            if (st_q[i] == ST_EXEC) begin
                exec_found = 1'b1;
                exec_idx   = IW'(i);
            end
            if (st_q[i] == ST_DONE) begin
                done_found = 1'b1;
                done_idx   = IW'(i);
            end
        end
    end

    assign cdb_hit = bus.cdb_valid && (bus.cdb_tag != '0);
    assign byp_j   = cdb_hit && (bus.cdb_tag == bus.disp_qj);
    assign byp_k   = cdb_hit && (bus.cdb_tag == bus.disp_qk);

    assign bus.disp_ready = free_found;
    assign bus.disp_tag   = TAG_W'(BASE_TAG) + TAG_W'(free_idx);
    assign bus.out_req    = done_found;
    assign bus.out_tag    = done_found ? (TAG_W'(BASE_TAG) + TAG_W'(done_idx)) : '0;
    assign bus.out_data   = done_found ? res_q[done_idx] : '0;
    assign bus.fu_en      = fu_en_q;
    assign bus.fu_a       = fu_a_q;
    assign bus.fu_b       = fu_b_q;

    // Next-state: flush overrides everything; otherwise snoop, complete, issue, grant, dispatch
    always_comb begin
        fu_busy_d = fu_busy_q;
        orphan_d  = orphan_q;
        fu_en_d   = 1'b0;
        fu_a_d    = fu_a_q;
        fu_b_d    = fu_b_q;
        for (int i = 0; i < N_ENT; i++) begin
            st_d[i]  = st_q[i];
            qj_d[i]  = qj_q[i];
            qk_d[i]  = qk_q[i];
            vj_d[i]  = vj_q[i];
            vk_d[i]  = vk_q[i];
            res_d[i] = res_q[i];
        end

        if (bus.flush) begin
            for (int i = 0; i < N_ENT; i++) begin
                st_d[i] = ST_FREE;
            end
            // A divide finishing on the flush edge leaves nothing stale behind
            if (bus.fu_finish && fu_busy_q) begin
                fu_busy_d = 1'b0;
                orphan_d  = 1'b0;
            end else if (exec_found) begin
                orphan_d = 1'b1;
            end
        end else begin
            if (cdb_hit) begin
                for (int i = 0; i < N_ENT; i++) begin
                    if (st_q[i] == ST_WAIT && qj_q[i] == bus.cdb_tag) begin
                        qj_d[i] = '0;
                        vj_d[i] = bus.cdb_data;
                    end
                    if (st_q[i] == ST_WAIT && qk_q[i] == bus.cdb_tag) begin
                        qk_d[i] = '0;
                        vk_d[i] = bus.cdb_data;
                    end
                end
            end

            if (bus.fu_finish) begin
                if (orphan_q) begin
                    orphan_d  = 1'b0;
                    fu_busy_d = 1'b0;
                end else if (exec_found) begin
                    st_d[exec_idx]  = ST_DONE;
                    res_d[exec_idx] = bus.fu_res;
                    fu_busy_d       = 1'b0;
                end
            end

            // Readiness comes from registered tags, so freshly written operands wait a cycle
            if (!fu_busy_q && !orphan_q && rdy_found) begin
                st_d[rdy_idx] = ST_EXEC;
                fu_en_d       = 1'b1;
                fu_a_d        = vj_q[rdy_idx];
                fu_b_d        = vk_q[rdy_idx];
                fu_busy_d     = 1'b1;
            end

            if (bus.out_grant && done_found) begin
                st_d[done_idx] = ST_FREE;
            end

            if (bus.disp_valid && free_found) begin
                st_d[free_idx] = ST_WAIT;
                qj_d[free_idx] = byp_j ? '0 : bus.disp_qj;
                vj_d[free_idx] = byp_j ? bus.cdb_data : bus.disp_vj;
                qk_d[free_idx] = byp_k ? '0 : bus.disp_qk;
                vk_d[free_idx] = byp_k ? bus.cdb_data : bus.disp_vk;
            end
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENT; i++) begin
                st_q[i]  <= ST_FREE;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
                res_q[i] <= '0;
            end
            fu_busy_q <= 1'b0;
            orphan_q  <= 1'b0;
            fu_en_q   <= 1'b0;
            fu_a_q    <= '0;
            fu_b_q    <= '0;
        end else begin
            for (int i = 0; i < N_ENT; i++) begin
                st_q[i]  <= st_d[i];
                qj_q[i]  <= qj_d[i];
                qk_q[i]  <= qk_d[i];
                vj_q[i]  <= vj_d[i];
                vk_q[i]  <= vk_d[i];
                res_q[i] <= res_d[i];
            end
            fu_busy_q <= fu_busy_d;
            orphan_q  <= orphan_d;
            fu_en_q   <= fu_en_d;
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
        end
    end
endmodule
